egg_countdown: RTL



---
 rtl/egg_countdown_pkg.sv | 24 ++
 rtl/egg_countdown_if.sv | 28 ++
 rtl/egg_countdown_bcd_digit_dec.sv | 25 ++
 rtl/egg_countdown.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/egg_countdown_pkg.sv
// Shared definitions for the egg timer countdown: FSM encodings, BCD digit
// limits, divider defaults and the digit clamp used when loading switches.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RUN   = 3'b001,
        PAUSE = 3'b010,
        FLASH = 3'b011
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
    localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;

    localparam int TICK_DIV_DEFAULT     = 50_000_000;
    localparam int FLASH_DIV_DEFAULT    = 25_000_000;
    localparam int FLASH_CYCLES_DEFAULT = 10;

    // Saturate a raw switch nibble to the largest legal digit for its place.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

endpackage

// File: rtl/egg_countdown_if.sv
// Control/display bundle between the key decode, the countdown core and the
// display stage. The core is the slave; whoever drives the keys is the master.
interface egg_countdown_if;
    import egg_timer_pkg::*;

    logic [7:0] bcd_in;
    logic       load_sec;
    logic       load_min;
    logic       start;
    logic       stop;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       flash;
    state_t     state;

    modport master (
        output bcd_in, load_sec, load_min, start, stop,
        input  min_bcd, sec_bcd, running, done, flash, state
    );

    modport slave (
        input  bcd_in, load_sec, load_min, start, stop,
        output min_bcd, sec_bcd, running, done, flash, state
    );

endinterface

// File: rtl/egg_countdown_bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain: when enabled, a zero digit wraps
// to its place maximum and borrows from the next place up.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] wrap,
    input  logic       en,
    output logic [3:0] digit_next,
    output logic       borrow
);

    // Decrement with wrap-and-borrow at zero; pass through when not enabled.
    always_comb begin
        digit_next = digit;
        borrow     = 1'b0;
        if (en) begin
            if (digit == 4'd0) begin
                digit_next = wrap;
                borrow     = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/egg_countdown.sv
// Egg timer countdown core: holds MM:SS in packed BCD, counts down once per
// tick while running, then flashes for a fixed number of toggles at 00:00.
// Optional build macro EGG_COUNTDOWN_HOLD_EN keeps a copy of the last loaded
// time and restores it when the flash phase ends.
module egg_countdown
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int FLASH_DIV    = FLASH_DIV_DEFAULT,
    parameter int FLASH_CYCLES = FLASH_CYCLES_DEFAULT
) (
    input  logic           CLOCK_50,
    input  logic           rst,
    egg_countdown_if.slave bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam int PW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_CYCLES - 1);

    state_t        state_reg;
    logic [7:0]    min_bcd_reg;
    logic [7:0]    sec_bcd_reg;
    logic          running_reg;
    logic          done_reg;
    logic          flash_reg;
    logic [TW-1:0] tick_cnt_reg;
    logic [FW-1:0] flash_div_reg;
    logic [PW-1:0] flash_phase_reg;
`ifdef EGG_COUNTDOWN_HOLD_EN
    logic [7:0]    hold_min_reg;
    logic [7:0]    hold_sec_reg;
`endif

    logic [15:0] cur_val;
    logic [15:0] dec_val;
    logic [3:0]  en_vec;
    logic [3:0]  borrow_vec;
    logic        tick_due;
    logic        tick_apply;
    logic        hits_zero;
    logic        is_zero;
    logic        flash_wrap;
    logic        flash_exit;
    logic [7:0]  load_min_val;
    logic [7:0]  load_sec_val;

    // Digit order, least significant first: sec ones, sec tens, min ones, min tens.
    assign cur_val = {min_bcd_reg, sec_bcd_reg};
    assign en_vec  = {borrow_vec[2:0], 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] WRAP = (gi == 1) ? BCD_SEC_TENS_MAX : BCD_DIGIT_MAX;
            bcd_digit_dec u_dec (
                .digit      (cur_val[gi*4 +: 4]),
                .wrap       (WRAP),
                .en         (en_vec[gi]),
                .digit_next (dec_val[gi*4 +: 4]),
                .borrow     (borrow_vec[gi])
            );
        end
    endgenerate

    // A borrow out of the top digit would mean decrementing 00:00; never apply it.
    assign tick_due   = (state_reg == RUN) && (tick_cnt_reg == TICK_LAST);
    assign tick_apply = tick_due && !borrow_vec[3];
    assign hits_zero  = tick_apply && (dec_val == 16'h0000);
    assign is_zero    = (cur_val == 16'h0000);
    assign flash_wrap = (flash_div_reg == FLASH_LAST);
    assign flash_exit = (state_reg == FLASH) &&
                        (bus.stop || bus.start || (flash_wrap && flash_phase_reg == PHASE_LAST));

    assign load_min_val = {clamp_digit(bus.bcd_in[7:4], BCD_DIGIT_MAX),
                           clamp_digit(bus.bcd_in[3:0], BCD_DIGIT_MAX)};
    assign load_sec_val = {clamp_digit(bus.bcd_in[7:4], BCD_SEC_TENS_MAX),
                           clamp_digit(bus.bcd_in[3:0], BCD_DIGIT_MAX)};

    // Sequencer: pulse priority stop > start > load_min > load_sec, all outputs registered.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_reg       <= IDLE;
            min_bcd_reg     <= 8'h00;
            sec_bcd_reg     <= 8'h00;
            running_reg     <= 1'b0;
            done_reg        <= 1'b0;
            flash_reg       <= 1'b0;
            tick_cnt_reg    <= '0;
            flash_div_reg   <= '0;
            flash_phase_reg <= '0;
`ifdef EGG_COUNTDOWN_HOLD_EN
            hold_min_reg    <= 8'h00;
            hold_sec_reg    <= 8'h00;
`endif
        end else begin
            unique case (state_reg)
                IDLE, PAUSE: begin
                    if (bus.stop) begin
                        // Nothing to pause; lower-priority pulses are dropped.
                    end else if (bus.start) begin
                        if (!is_zero) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                            // A fresh run starts a full second; a resume keeps the partial count.
                            if (state_reg == IDLE) begin
                                tick_cnt_reg <= '0;
                            end
                        end
                    end else if (bus.load_min) begin
                        min_bcd_reg  <= load_min_val;
`ifdef EGG_COUNTDOWN_HOLD_EN
                        hold_min_reg <= load_min_val;
`endif
                    end else if (bus.load_sec) begin
                        sec_bcd_reg  <= load_sec_val;
`ifdef EGG_COUNTDOWN_HOLD_EN
                        hold_sec_reg <= load_sec_val;
`endif
                    end
                end
                RUN: begin
                    // The cycle on which stop arrives still counts as run time.
                    tick_cnt_reg <= tick_due ? '0 : tick_cnt_reg + 1'b1;
                    if (tick_apply) begin
                        {min_bcd_reg, sec_bcd_reg} <= dec_val;
                    end
                    if (hits_zero) begin
                        state_reg       <= FLASH;
                        running_reg     <= 1'b0;
                        done_reg        <= 1'b1;
                        flash_reg       <= 1'b1;
                        flash_div_reg   <= '0;
                        flash_phase_reg <= '0;
                    end else if (bus.stop) begin
                        state_reg   <= PAUSE;
                        running_reg <= 1'b0;
                    end
                end
                FLASH: begin
                    if (flash_exit) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                        flash_reg <= 1'b0;
`ifdef EGG_COUNTDOWN_HOLD_EN
                        min_bcd_reg <= hold_min_reg;
                        sec_bcd_reg <= hold_sec_reg;
`endif
                    end else if (flash_wrap) begin
                        flash_div_reg   <= '0;
                        flash_phase_reg <= flash_phase_reg + 1'b1;
                        flash_reg       <= ~flash_reg;
                    end else begin
                        flash_div_reg <= flash_div_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                    flash_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_bcd = min_bcd_reg;
    assign bus.sec_bcd = sec_bcd_reg;
    assign bus.running = running_reg;
    assign bus.done    = done_reg;
    assign bus.flash   = flash_reg;
    assign bus.state   = state_reg;

endmodule
